// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter and controller: state encoding,
// address/data widths and a small port-select helper.
package sdram_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_WAIT_RD = 2'd3
  } arb_state_e;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Two-way grant select. With SDRAM_ARB_RR_EN defined it is round-robin with a
// registered preference pointer; otherwise port 0 always wins.
module sdram_arb_pick
  import sdram_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       grant_i,
`endif
  input  logic [1:0] req_i,
  output logic       gnt_idx_o,
  output logic       any_o
);

  assign any_o = |req_i;

`ifdef SDRAM_ARB_RR_EN
  // ptr_q names the port currently holding top priority.
  logic ptr_q;
  logic ptr_d;

  // Prefer the pointed-at port, fall back to the other one.
  always_comb begin
    gnt_idx_o = ptr_q;
    ptr_d     = ptr_q;
    if (req_i[ptr_q]) begin
      gnt_idx_o = ptr_q;
    end else begin
      gnt_idx_o = ~ptr_q;
    end
    if (grant_i) begin
      ptr_d = ~gnt_idx_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: port 0 over port 1.
  always_comb begin
    gnt_idx_o = 1'b0;
    if (req_i[0]) begin
      gnt_idx_o = 1'b0;
    end else begin
      gnt_idx_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-transaction SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int         NREQ       = 2,
  parameter logic [7:0] RD_TIMEOUT = 8'd64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0]                req_rw,
  input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [NREQ-1:0]                rsp_err,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           ctl_in_valid,
  output logic                           ctl_rw,
  output logic [ADDR_W-1:0]              ctl_addr,
  output logic [DATA_W-1:0]              ctl_wdata,
  input  logic                           ctl_busy,
  input  logic                           ctl_out_valid,
  input  logic [DATA_W-1:0]              ctl_rdata
);

  arb_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              in_valid_q, in_valid_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ready_q, ready_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_idx;
  logic pick_any;
  logic grant;

  assign grant = (state_q == ST_IDLE) && pick_any && !ctl_busy;

  sdram_arb_pick u_pick (
`ifdef SDRAM_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .grant_i   (grant),
`endif
    .req_i     (req_valid),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Next-state and next-output logic; every output is computed one cycle early.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    in_valid_d = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 2'b00;
    rvalid_d   = 2'b00;
    rerr_d     = 2'b00;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d    = pick_idx;
          rw_d       = req_rw[pick_idx];
          addr_d     = req_addr[pick_idx];
          wdata_d    = req_wdata[pick_idx];
          in_valid_d = 1'b1;
          ready_d    = port_onehot(pick_idx);
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_SETTLE;
      end
      // Controller busy lags in_valid by a cycle; wait it out before IDLE.
      ST_SETTLE: begin
        if (rw_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_RD;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT_RD: begin
        if (ctl_out_valid) begin
          rvalid_d = port_onehot(owner_q);
          rdata_d  = ctl_rdata;
          state_d  = ST_IDLE;
        end else if (cnt_q == RD_TIMEOUT) begin
          rvalid_d = port_onehot(owner_q);
          rerr_d   = port_onehot(owner_q);
          rdata_d  = 32'h0000_0000;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      owner_q    <= 1'b0;
      in_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 2'b00;
      rvalid_q   <= 2'b00;
      rerr_q     <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      in_valid_q <= in_valid_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_err      = rerr_q;
  assign rsp_rdata    = rdata_q;
  assign ctl_in_valid = in_valid_q;
  assign ctl_rw       = rw_q;
  assign ctl_addr     = addr_q;
  assign ctl_wdata    = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_rw;
  logic [1:0][22:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_err;
  logic [31:0]       rsp_rdata;
  logic              ctl_in_valid;
  logic              ctl_rw;
  logic [22:0]       ctl_addr;
  logic [31:0]       ctl_wdata;
  logic              ctl_busy;
  logic              ctl_out_valid;
  logic [31:0]       ctl_rdata;

  int checks = 0;
  int errors = 0;

  sdram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_rdata     (rsp_rdata),
    .ctl_in_valid  (ctl_in_valid),
    .ctl_rw        (ctl_rw),
    .ctl_addr      (ctl_addr),
    .ctl_wdata     (ctl_wdata),
    .ctl_busy      (ctl_busy),
    .ctl_out_valid (ctl_out_valid),
    .ctl_rdata     (ctl_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seen;
  logic [1:0] gnt;
  logic [1:0] exp_gnt [4];
  int         n;
  bit         found;

  initial begin
`ifdef SDRAM_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst = 1'b1; req_valid = 2'b00; req_rw = 2'b00; req_addr = '0; req_wdata = '0;
    ctl_busy = 1'b0; ctl_out_valid = 1'b0; ctl_rdata = 32'h0;
    step(); step();
    check("rst_in_valid", {31'd0, ctl_in_valid}, 32'd0);
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp", {28'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_addr", {9'd0, ctl_addr}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;

    // Single write from port 0
    req_valid = 2'b01; req_rw = 2'b01; req_addr[0] = 23'h000400; req_wdata[0] = 32'hDEADBEEF;
    step();
    check("wr_in_valid", {31'd0, ctl_in_valid}, 32'd1);
    check("wr_rw", {31'd0, ctl_rw}, 32'd1);
    check("wr_addr", {9'd0, ctl_addr}, 32'h400);
    check("wr_wdata", ctl_wdata, 32'hDEADBEEF);
    check("wr_ready", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    step();
    check("wr_in_valid_drop", {31'd0, ctl_in_valid}, 32'd0);
    check("wr_ready_drop", {30'd0, req_ready}, 32'd0);
    check("wr_addr_hold", {9'd0, ctl_addr}, 32'h400);
    seen = 2'b00;
    for (int i = 0; i < 4; i++) begin
      seen |= rsp_valid;
      step();
    end
    check("wr_no_rsp", {30'd0, seen}, 32'd0);

    // Single read from port 1
    req_valid = 2'b10; req_rw = 2'b00; req_addr[1] = 23'h000010;
    step();
    check("rd_in_valid", {31'd0, ctl_in_valid}, 32'd1);
    check("rd_rw", {31'd0, ctl_rw}, 32'd0);
    check("rd_addr", {9'd0, ctl_addr}, 32'h10);
    check("rd_ready", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    step(); step();
    ctl_out_valid = 1'b1; ctl_rdata = 32'h12345678;
    step();
    ctl_out_valid = 1'b0;
    check("rd_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    check("rd_rsp_err", {30'd0, rsp_err}, 32'd0);
    check("rd_rdata", rsp_rdata, 32'h12345678);
    step();
    check("rd_rsp_pulse", {30'd0, rsp_valid}, 32'd0);

    // Busy hold-off
    ctl_busy = 1'b1; req_valid = 2'b01; req_rw = 2'b01; req_addr[0] = 23'h000005;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ctl_in_valid) found = 1'b1;
    end
    check("busy_hold", {31'd0, found}, 32'd0);
    ctl_busy = 1'b0;
    step();
    check("busy_release", {31'd0, ctl_in_valid}, 32'd1);
    check("busy_addr", {9'd0, ctl_addr}, 32'h5);
    req_valid = 2'b00;
    step(); step(); step();

    // Read timeout
    req_valid = 2'b01; req_rw = 2'b00; req_addr[0] = 23'h000077;
    step();
    check("to_in_valid", {31'd0, ctl_in_valid}, 32'd1);
    req_valid = 2'b00;
    found = 1'b0; n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (rsp_valid != 2'b00) begin
        found = 1'b1; n = i;
        break;
      end
    end
    check("to_found", {31'd0, found}, 32'd1);
    check("to_latency", n, 32'd67);
    check("to_valid", {30'd0, rsp_valid}, 32'd1);
    check("to_err", {30'd0, rsp_err}, 32'd1);
    check("to_rdata", rsp_rdata, 32'd0);
    ctl_out_valid = 1'b1; ctl_rdata = 32'hAAAA5555;
    step();
    ctl_out_valid = 1'b0;
    check("late_ignored", {30'd0, rsp_valid}, 32'd0);
    step();
    check("late_rdata", rsp_rdata, 32'd0);

    // Reset while waiting for read data
    req_valid = 2'b10; req_rw = 2'b00; req_addr[1] = 23'h000123;
    step();
    req_valid = 2'b00;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_addr", {9'd0, ctl_addr}, 32'd0);
    check("mid_rst_out", {27'd0, ctl_in_valid, rsp_valid, rsp_err}, 32'd0);
    seen = 2'b00;
    ctl_out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= rsp_valid;
    end
    ctl_out_valid = 1'b0;
    check("mid_rst_no_rsp", {30'd0, seen}, 32'd0);

    // Contention: both ports read continuously
    req_valid = 2'b11; req_rw = 2'b00; req_addr[0] = 23'h000100; req_addr[1] = 23'h000200;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (ctl_in_valid) begin
          found = 1'b1;
          break;
        end
      end
      check("ct_found", {31'd0, found}, 32'd1);
      gnt = req_ready;
      check($sformatf("ct_gnt%0d", k), {30'd0, gnt}, {30'd0, exp_gnt[k]});
      step(); step();
      ctl_out_valid = 1'b1; ctl_rdata = 32'hC0DE0000 + k;
      step();
      ctl_out_valid = 1'b0;
      check($sformatf("ct_rsp%0d", k), {30'd0, rsp_valid}, {30'd0, exp_gnt[k]});
      check($sformatf("ct_data%0d", k), rsp_rdata, 32'hC0DE0000 + k);
    end
    req_valid = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, number of requester ports (fixed at 2 in this revision).
REQ-002 The block SHALL have parameter RD_TIMEOUT, default 8'd64, maximum cycles to wait for read data.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  2  per-port request, held until accepted.
- req_rw  in  2  per-port direction: 1 = write, 0 = read.
- req_addr  in  2x23  per-port word address.
- req_wdata  in  2x32  per-port write data.
- req_ready  out  2  one-cycle accept pulse per port.
- rsp_valid  out  2  one-cycle read-data pulse per port.
- rsp_err  out  2  qualifies rsp_valid: read timed out.
- rsp_rdata  out  32  read data, shared by both ports.
- ctl_in_valid  out  1  to controller in_valid.
- ctl_rw  out  1  to controller rw.
- ctl_addr  out  23  to controller user_addr.
- ctl_wdata  out  32  to controller data_in.
- ctl_busy  in  1  from controller busy.
- ctl_out_valid  in  1  from controller out_valid.
- ctl_rdata  in  32  from controller data_out.

Function
REQ-004 The block SHALL have these states: IDLE, ISSUE, SETTLE, WAIT_RD.
REQ-005 In IDLE, when any req_valid is high and ctl_busy is low, the block SHALL select one port, latch its rw, addr and wdata, and go to ISSUE.
REQ-006 In ISSUE, the block SHALL drive ctl_in_valid=1 with the latched fields and pulse req_ready of the granted port, both for exactly one cycle; the grant occurs 1 cycle after acceptance in IDLE.
REQ-007 The block SHALL go from ISSUE to SETTLE for one cycle, masking the one-cycle lag before ctl_busy rises.
REQ-008 From SETTLE, a write SHALL return to IDLE and a read SHALL go to WAIT_RD.
REQ-009 In WAIT_RD, on ctl_out_valid, the block SHALL register ctl_rdata into rsp_rdata, pulse rsp_valid of the owning port for one cycle with rsp_err=0, and go to IDLE.
REQ-010 In WAIT_RD, an 8-bit counter SHALL start at 0; when it reaches RD_TIMEOUT the block SHALL pulse rsp_valid and rsp_err of the owner, set rsp_rdata=32'h0, and go to IDLE.
REQ-011 A ctl_out_valid that arrives outside WAIT_RD SHALL be ignored.
REQ-012 At most one controller transaction SHALL be outstanding; no issue occurs while ctl_busy=1 or in ISSUE, SETTLE or WAIT_RD.
REQ-013 A req_valid that drops before its grant SHALL cause no transaction; fields latched at grant SHALL be the ones used.
REQ-014 All outputs SHALL be registered; ctl_* fields SHALL hold their latched values outside ISSUE, with ctl_in_valid=0.

Reset
REQ-015 On rst=1 at a clk edge, the block SHALL set state=IDLE; req_ready, rsp_valid, rsp_err and ctl_in_valid to 0; ctl_rw, ctl_addr, ctl_wdata and rsp_rdata to 0; timeout counter to 0; priority pointer to port 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction silently with no rsp_valid.

Configuration
REQ-017 With SDRAM_ARB_RR_EN defined, arbitration SHALL be round-robin: the last-granted port has lowest priority, and the pointer updates only on grant.
REQ-018 Without SDRAM_ARB_RR_EN, arbitration SHALL be fixed priority, port 0 over port 1; the pointer logic SHALL be absent.

Structure
REQ-019 The shared package sdram_pkg SHALL hold the state encodings, the address width (23) and the data width (32), shared with the SDRAM controller.
REQ-020 A sub-module sdram_arb_pick SHALL contain the combinational 2-way grant select plus the round-robin pointer register.

Verification
REQ-021 Single write: port0 write addr=23'h000400, data=32'hDEADBEEF with ctl_busy=0 -> ctl_in_valid one cycle, ctl_rw=1, ctl_addr=23'h000400, req_ready[0] 1 cycle after valid, no rsp_valid.
REQ-022 Single read: port1 read addr=23'h000010; ctl_out_valid with ctl_rdata=32'h12345678 -> rsp_valid[1]=1, rsp_err[1]=0, rsp_rdata=32'h12345678, rsp_valid[0] stays 0.
REQ-023 Contention: both ports valid continuously with reads -> with macro, grants alternate 0,1,0,1; without macro, port 0 is granted every time.
REQ-024 Busy hold-off: ctl_busy=1 for 10 cycles while req_valid[0]=1 -> no ctl_in_valid until 1 cycle after ctl_busy falls.
REQ-025 Timeout: read issued with no ctl_out_valid -> after 64 WAIT_RD cycles, rsp_valid=rsp_err=1 for the owner and rsp_rdata=0; a late ctl_out_valid is ignored.
REQ-026 Reset in WAIT_RD: assert rst for one cycle -> all outputs 0, state IDLE, no rsp_valid.
